// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared writeback payload definitions. The field widths and
//               requester indices here are common to the writeback arbiter,
//               the ROB and the LSQ.
//               Contents: ROBID_W, ECAUSE_W, XLEN, WB_W (packed payload
//               width), req_idx_e (requester port numbering) and
//               wb_payload_t (packed writeback payload).
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int ROBID_W  = 7;   // includes the ROB polarity bit
    localparam int ECAUSE_W = 5;
    localparam int XLEN     = 32;
    localparam int WB_W     = 1 + ECAUSE_W + ROBID_W + XLEN;

    // Fixed assignment of execution units to arbiter ports
    typedef enum logic [1:0] {
        REQ_ALU    = 2'd0,
        REQ_BRANCH = 2'd1,
        REQ_LSQ    = 2'd2,
        REQ_MULDIV = 2'd3
    } req_idx_e;

    typedef struct packed {
        logic                error;
        logic [ECAUSE_W-1:0] ecause;
        logic [ROBID_W-1:0]  robid;
        logic [XLEN-1:0]     result;
    } wb_payload_t;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-entry circular-buffer FIFO for one writeback requester.
//               A push is ignored while full and a pop while empty; flush
//               clears all pointers and discards any same-cycle push/pop.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_flush        - discard contents
//               i_push / i_din - write request and data
//               i_pop          - remove head entry
//               o_full/o_empty - occupancy flags (registered count only)
//               o_head         - data at the head of the queue
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = WB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [c_addr_w-1:0] head_q, head_d;
    logic [c_addr_w-1:0] tail_q, tail_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic                w_push;
    logic                w_pop;

    assign o_full  = (count_q == c_full);
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[head_q];

    // Gating on the registered full flag means a simultaneous pop can never
    // make room for a push in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                mem_d[tail_q] = i_din;
                tail_d        = tail_q + c_addr_w'(1);   // wraps naturally
            end
            if (w_pop) begin
                head_d = head_q + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cnt_w'(1);
                2'b01:   count_d = count_q - c_cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Shares the single ROB writeback port among NREQ execution
//               units. Each unit pushes into a private wb_fifo; a round-robin
//               arbiter drains one entry per cycle onto the registered wb_*
//               bus. rob_flush discards everything buffered.
// Ports       : clk, rst                   - clock, sync active-high reset
//               rob_flush                  - discard pending results
//               req_valid/req_ready        - per-requester handshake
//               req_error/ecause/robid/result - packed per-requester payload
//               wb_valid/error/ecause/robid/result - registered writeback beat
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rob_flush,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_error,
    input  logic [ECAUSE_W*NREQ-1:0] req_ecause,
    input  logic [ROBID_W*NREQ-1:0]  req_robid,
    input  logic [XLEN*NREQ-1:0]     req_result,
    output logic                     wb_valid,
    output logic                     wb_error,
    output logic [ECAUSE_W-1:0]      wb_ecause,
    output logic [ROBID_W-1:0]       wb_robid,
    output logic [XLEN-1:0]          wb_result
);

    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_payload_t          fifo_head [NREQ];
    logic [NREQ-1:0]      fifo_full;
    logic [NREQ-1:0]      fifo_empty;
    logic [NREQ-1:0]      fifo_pop;

    logic [c_ptr_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_ptr_w-1:0]   grant_idx;
    logic                 grant_any;

    logic                 wb_valid_q, wb_valid_d;
    wb_payload_t          wb_data_q, wb_data_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            wb_payload_t w_din;

            assign w_din.error  = req_error[gi];
            assign w_din.ecause = req_ecause[gi*ECAUSE_W +: ECAUSE_W];
            assign w_din.robid  = req_robid[gi*ROBID_W +: ROBID_W];
            assign w_din.result = req_result[gi*XLEN +: XLEN];

            assign fifo_pop[gi]  = grant_any && (grant_idx == c_ptr_w'(gi));
            assign req_ready[gi] = ~fifo_full[gi];

            wb_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (WB_W)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_flush (rob_flush),
                .i_push  (req_valid[gi]),
                .i_pop   (fifo_pop[gi]),
                .i_din   (w_din),
                .o_full  (fifo_full[gi]),
                .o_empty (fifo_empty[gi]),
                .o_head  (fifo_head[gi])
            );
        end
    endgenerate

    // Round-robin search: first non-empty FIFO at or after rr_ptr, modulo NREQ.
    always_comb begin
        int                 idx;
        logic [c_ptr_w-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(rr_ptr_q) + k) % NREQ;
            cand = c_ptr_w'(idx);
            if (!grant_any && !fifo_empty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_valid_d = grant_any;
        wb_data_d  = wb_data_q;
        if (grant_any) begin
            rr_ptr_d  = c_ptr_w'((int'(grant_idx) + 1) % NREQ);
            wb_data_d = fifo_head[grant_idx];
        end
        // The FIFOs discard this cycle's pop themselves; only the beat and
        // the pointer need suppressing here.
        if (rob_flush) begin
            rr_ptr_d   = '0;
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_error  = wb_data_q.error;
    assign wb_ecause = wb_data_q.ecause;
    assign wb_robid  = wb_data_q.robid;
    assign wb_result = wb_data_q.result;

endmodule : wb_arbiter
`default_nettype wire
